sdram_write_ctrl: RTL and testbench

- Write-command generator feeding the SDRAM arbiter's write slot.
- Requests the bus, then issues ACTIVE / WRITE-burst / PRECHARGE sequences from a show-ahead FIFO. Walks row/column addresses linearly across one frame.
- Yields to refresh at burst boundaries and resumes at the interrupted address.

---
 rtl/sdram_write_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sdram_write_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_write_ctrl.sv
// SDRAM write-command generator: turns arbiter grants into ACTIVE / WRITE-burst / PRECHARGE
// sequences fed from a show-ahead FIFO, walking row/column addresses linearly across one frame.
module sdram_write_ctrl #(
    parameter int BURST_LEN   = 4,
    parameter int COL_MAX     = 512,
    parameter int FRAME_WORDS = 307200,
    parameter int TRCD        = 2,
    parameter int TRP         = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_trig,
    input  logic        wr_en,
    input  logic        ref_req,
    output logic        wr_req,
    output logic        flag_wr_end,
    output logic [3:0]  wr_cmd,
    output logic [12:0] wr_addr,
    output logic [15:0] wr_dq,
    output logic        fifo_rd_en,
    input  logic [15:0] fifo_rd_data,
    output logic        frame_done
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WW = $clog2(FRAME_WORDS + 1);
    localparam int CW = (TRCD > TRP) ? $clog2(TRCD + 1) : $clog2(TRP + 1);

    localparam logic [BW-1:0] B_LAST    = BW'(BURST_LEN - 1);
    localparam logic [CW-1:0] ACT_LAST  = CW'(TRCD - 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(TRP - 1);
    localparam logic [12:0]   COL_LAST  = 13'(COL_MAX - BURST_LEN);
    localparam logic [12:0]   COL_STEP  = 13'(BURST_LEN);
    localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - BURST_LEN);
    localparam logic [WW-1:0] WORD_STEP = WW'(BURST_LEN);

    typedef enum logic [1:0] {S_IDLE, S_ACT, S_WR, S_PRE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [12:0]   row_q, row_d;
    logic [12:0]   col_q, col_d;
    logic [WW-1:0] word_q, word_d;
    logic          frame_end_q, frame_end_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            burst_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            word_q      <= '0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            burst_q     <= burst_d;
            row_q       <= row_d;
            col_q       <= col_d;
            word_q      <= word_d;
            frame_end_q <= frame_end_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        burst_d     = burst_q;
        row_d       = row_q;
        col_d       = col_q;
        word_d      = word_q;
        frame_end_d = frame_end_q;

        wr_req      = 1'b0;
        flag_wr_end = 1'b0;
        frame_done  = 1'b0;
        fifo_rd_en  = 1'b0;
        wr_cmd      = CMD_NOP;
        wr_addr     = 13'h0000;
        wr_dq       = 16'h0000;

        case (state_q)
            S_IDLE: begin
                // Gated so the request reads low while reset is held.
                wr_req = wr_trig & rst_n;
                if (wr_en) begin
                    state_d = S_ACT;
                    wait_d  = '0;
                end
            end

            S_ACT: begin
                if (wait_q == '0) begin
                    wr_cmd  = CMD_ACT;
                    wr_addr = row_q;
                end
                if (wait_q == ACT_LAST) begin
                    state_d = S_WR;
                    burst_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_WR: begin
                fifo_rd_en = 1'b1;
                wr_dq      = fifo_rd_data;
                if (burst_q == '0) begin
                    wr_cmd  = CMD_WR;
                    wr_addr = col_q;
                end
                if (burst_q == B_LAST) begin
                    burst_d = '0;
                    wait_d  = '0;
                    col_d   = (col_q == COL_LAST) ? 13'h0000 : col_q + COL_STEP;
                    word_d  = word_q + WORD_STEP;
                    // Frame end beats row end, which beats refresh / starvation.
                    if (word_q == WORD_LAST) begin
                        frame_end_d = 1'b1;
                        row_d       = '0;
                        col_d       = '0;
                        word_d      = '0;
                        state_d     = S_PRE;
                    end else if (col_q == COL_LAST) begin
                        row_d   = row_q + 13'd1;
                        state_d = S_PRE;
                    end else if (ref_req || !wr_trig) begin
                        state_d = S_PRE;
                    end
                end else begin
                    burst_d = burst_q + 1'b1;
                end
            end

            S_PRE: begin
                if (wait_q == '0) begin
                    wr_cmd  = CMD_PRE;
                    wr_addr = 13'h0400;
                end
                if (wait_q == PRE_LAST) begin
                    flag_wr_end = 1'b1;
                    frame_done  = frame_end_q;
                    frame_end_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sdram_write_ctrl.sv
// Directed bench for sdram_write_ctrl: single burst, row crossing, refresh yield,
// frame end (FRAME_WORDS overridden to 1040) and reset mid-burst.
module tb_sdram_write_ctrl;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WRC = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_trig, wr_en, ref_req;
    logic        wr_req, flag_wr_end, fifo_rd_en, frame_done;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [15:0] wr_dq, fifo_rd_data;

    sdram_write_ctrl #(
        .BURST_LEN   (4),
        .COL_MAX     (512),
        .FRAME_WORDS (1040),
        .TRCD        (2),
        .TRP         (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_trig      (wr_trig),
        .wr_en        (wr_en),
        .ref_req      (ref_req),
        .wr_req       (wr_req),
        .flag_wr_end  (flag_wr_end),
        .wr_cmd       (wr_cmd),
        .wr_addr      (wr_addr),
        .wr_dq        (wr_dq),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-sequence observations filled in by run_seq.
    int          n_act, n_wr, n_pre, n_pop, n_flag, n_fd;
    int          act_cyc, first_wr_cyc, pre_cyc, flag_cyc;
    int          gap_err, dq_err, req_err, fd_err, bad_cmd, timed_out;
    logic [12:0] act_addr, first_addr, last_addr, pre_addr;

    // Grants the bus once and records one full sequence up to flag_wr_end.
    task automatic run_seq(input string name, input bit drop_trig, input int ref_at);
        int cyc;
        int last_cyc;
        bit done;
        n_act = 0; n_wr = 0; n_pre = 0; n_pop = 0; n_flag = 0; n_fd = 0;
        act_cyc = -1; first_wr_cyc = -1; pre_cyc = -1; flag_cyc = -1;
        gap_err = 0; dq_err = 0; req_err = 0; fd_err = 0; bad_cmd = 0;
        act_addr = '1; first_addr = '1; last_addr = '1; pre_addr = '1;
        last_cyc = 0;
        done = 1'b0;
        cyc = 0;
        @(negedge clk);
        wr_en = 1'b1;
        if (drop_trig) wr_trig = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            wr_en = 1'b0;
            if (wr_req) req_err++;
            case (wr_cmd)
                ACT: begin n_act++; act_addr = wr_addr; act_cyc = cyc; end
                WRC: begin
                    if (n_wr == 0) begin
                        first_wr_cyc = cyc;
                        first_addr   = wr_addr;
                    end else if (cyc != last_cyc + 4 || wr_addr != last_addr + 13'd4) begin
                        gap_err++;
                    end
                    last_cyc  = cyc;
                    last_addr = wr_addr;
                    n_wr++;
                    if (n_wr == ref_at) ref_req = 1'b1;
                end
                PRE: begin n_pre++; pre_addr = wr_addr; pre_cyc = cyc; end
                NOP: ;
                default: bad_cmd++;
            endcase
            if (fifo_rd_en) begin
                n_pop++;
                if (wr_dq !== fifo_rd_data) dq_err++;
            end
            if (frame_done) begin
                n_fd++;
                if (!flag_wr_end) fd_err++;
            end
            if (flag_wr_end) begin
                n_flag++;
                flag_cyc = cyc;
                done = 1'b1;
            end
            fifo_rd_data = 16'($urandom);
        end
        timed_out = done ? 0 : 1;
        ref_req = 1'b0;
        $display("%s: act row %0d, writes %0d (cols %0d..%0d), pops %0d, pre %0d, flag@%0d, frame_done %0d",
                 name, act_addr, n_wr, first_addr, last_addr, n_pop, n_pre, flag_cyc, n_fd);
    endtask

    task automatic check_common(input string name);
        check_eq({name, "_timeout"}, 32'(timed_out), 0);
        check_eq({name, "_n_act"},   32'(n_act), 1);
        check_eq({name, "_n_pre"},   32'(n_pre), 1);
        check_eq({name, "_pre_addr"}, 32'(pre_addr), 32'h400);
        check_eq({name, "_n_flag"},  32'(n_flag), 1);
        check_eq({name, "_wr_req_low"}, 32'(req_err), 0);
        check_eq({name, "_bad_cmd"}, 32'(bad_cmd), 0);
        check_eq({name, "_dq"},      32'(dq_err), 0);
        check_eq({name, "_gap"},     32'(gap_err), 0);
        check_eq({name, "_pops"},    32'(n_pop), 32'(n_wr * 4));
        check_eq({name, "_pre_then_flag"}, 32'(flag_cyc - pre_cyc), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_cmd"},   32'(wr_cmd), 32'(NOP));
        check_eq({tag, "_addr"},  32'(wr_addr), 0);
        check_eq({tag, "_req"},   32'(wr_req), 0);
        check_eq({tag, "_flag"},  32'(flag_wr_end), 0);
        check_eq({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
        check_eq({tag, "_fdone"}, 32'(frame_done), 0);
    endtask

    initial begin
        int wr_seen;
        rst_n = 1'b0;
        wr_trig = 1'b1;
        wr_en = 1'b0;
        ref_req = 1'b0;
        fifo_rd_data = 16'h1234;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_wr_req", 32'(wr_req), 1);

        // Single burst, wr_trig drops together with the grant.
        run_seq("single", 1'b1, 0);
        check_common("single");
        check_eq("single_act_row", 32'(act_addr), 0);
        check_eq("single_act_lat", 32'(act_cyc), 1);
        check_eq("single_trcd",    32'(first_wr_cyc), 3);
        check_eq("single_n_wr",    32'(n_wr), 1);
        check_eq("single_col",     32'(first_addr), 0);
        check_eq("single_flag_cyc", 32'(flag_cyc), 8);
        check_eq("single_fd",      32'(n_fd), 0);
        check_eq("idle_req_low",   32'(wr_req), 0);

        // Continuous writing from col 4 to the row end.
        wr_trig = 1'b1;
        run_seq("rowend", 1'b0, 0);
        check_common("rowend");
        check_eq("rowend_act_row", 32'(act_addr), 0);
        check_eq("rowend_n_wr",    32'(n_wr), 127);
        check_eq("rowend_first",   32'(first_addr), 4);
        check_eq("rowend_last",    32'(last_addr), 508);

        // Refresh requested during the third burst of row 1.
        run_seq("refresh", 1'b0, 3);
        check_common("refresh");
        check_eq("refresh_act_row", 32'(act_addr), 1);
        check_eq("refresh_n_wr",    32'(n_wr), 3);
        check_eq("refresh_first",   32'(first_addr), 0);
        check_eq("refresh_last",    32'(last_addr), 8);

        // Resume at col 12; refresh arrives on the final burst of the row.
        run_seq("row_ref", 1'b0, 125);
        check_common("row_ref");
        check_eq("row_ref_act_row", 32'(act_addr), 1);
        check_eq("row_ref_first",   32'(first_addr), 12);
        check_eq("row_ref_last",    32'(last_addr), 508);
        check_eq("row_ref_n_wr",    32'(n_wr), 125);

        // 1024 words written; four more bursts on row 2 complete the 1040-word frame.
        run_seq("frame", 1'b0, 0);
        check_common("frame");
        check_eq("frame_act_row", 32'(act_addr), 2);
        check_eq("frame_n_wr",    32'(n_wr), 4);
        check_eq("frame_last",    32'(last_addr), 12);
        check_eq("frame_fd",      32'(n_fd), 1);
        check_eq("frame_fd_flag", 32'(fd_err), 0);

        // Counters restart at row 0, col 0 after the frame.
        run_seq("restart", 1'b1, 0);
        check_common("restart");
        check_eq("restart_act_row", 32'(act_addr), 0);
        check_eq("restart_col",     32'(first_addr), 0);
        check_eq("restart_fd",      32'(n_fd), 0);

        // Reset during the third burst of a new sequence.
        wr_trig = 1'b1;
        @(negedge clk);
        wr_en = 1'b1;
        wr_seen = 0;
        for (int i = 0; i < 40 && wr_seen < 3; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (wr_cmd == WRC) wr_seen++;
        end
        check_eq("rst_reached_burst3", 32'(wr_seen), 3);
        @(negedge clk);
        check_eq("rst_pre_rd_en", 32'(fifo_rd_en), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        @(negedge clk);
        check_idle_outputs("rst_held");
        rst_n = 1'b1;
        run_seq("after_rst", 1'b1, 0);
        check_common("after_rst");
        check_eq("after_rst_act_row", 32'(act_addr), 0);
        check_eq("after_rst_col",     32'(first_addr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
